// File: rtl/dcoffset_ramp_if.sv
// Offset-path bus: requested code and load enable in, DAC code and status out.
interface dcoffset_ramp_if #(
    parameter int unsigned WIDTH = 12
);
    logic [WIDTH-1:0] din;
    logic             en;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;

    modport master (output din, output en, input dout, input busy, input done);
    modport slave  (input din, input en, output dout, output busy, output done);
endinterface

// File: rtl/dcoffset_ramp_path.sv
// DC-offset DAC path: retiming pipeline, load-enabled output stage and an optional slew limiter.
// Define DCOFFSET_SLEW_EN to build the target register and ramp FSM; otherwise Dout loads the tail directly.
//
// state | meaning
// IDLE  | Dout equals the loaded target
// RAMP  | Dout is stepping toward the loaded target
module dcoffset_ramp_path #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned STEP    = 16,
    parameter int unsigned RST_VAL = 2048
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dcoffset_ramp_if.slave bus_io
);
    if (WIDTH < 4) begin : g_bad_width
        $error("dcoffset_ramp_path: WIDTH must be at least 4");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("dcoffset_ramp_path: DEPTH must be at least 1");
    end
    if (STEP < 1 || STEP >= (2 ** WIDTH)) begin : g_bad_step
        $error("dcoffset_ramp_path: STEP must be in 1 .. 2^WIDTH-1");
    end

    localparam logic [WIDTH-1:0] RST_CODE = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_CODE;
        end else begin
            stage_q[0] <= bus_io.din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tail = stage_q[DEPTH-1];

`ifdef DCOFFSET_SLEW_EN
    typedef enum logic {IDLE, RAMP} state_t;

    localparam logic [WIDTH-1:0] STEP_C = WIDTH'(STEP);
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   mag;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            target_q <= RST_CODE;
            dout_q   <= RST_CODE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    // The step always uses the target held before this edge, even when a new one loads.
    always_comb begin
        target_d = target_q;
        dout_d   = dout_q;
        state_d  = IDLE;
        done_d   = 1'b0;
        diff     = {1'b0, target_q} - {1'b0, dout_q};
        mag      = diff[WIDTH] ? -diff : diff;

        if (bus_io.en) target_d = tail;

        if (mag <= STEP_W)   dout_d = target_q;
        else if (!diff[WIDTH]) dout_d = dout_q + STEP_C;
        else                 dout_d = dout_q - STEP_C;

        if (dout_d != target_d) state_d = RAMP;
        done_d = (state_q == RAMP) && (state_d == IDLE);
    end

    assign bus_io.busy = (state_q == RAMP);
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q <= RST_CODE;
            done_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        dout_d = dout_q;
        done_d = bus_io.en;
        if (bus_io.en) dout_d = tail;
    end

    assign bus_io.busy = 1'b0;
`endif

    assign bus_io.dout = dout_q;
    assign bus_io.done = done_q;
endmodule

// File: tb/tb_dcoffset_ramp_path.sv
// Bench for dcoffset_ramp_path (WIDTH=12, DEPTH=2, STEP=16, RST_VAL=0x800), default or slew build.
module tb_dcoffset_ramp_path;
    logic clk;
    logic rst;

    dcoffset_ramp_if #(.WIDTH(12)) bus ();

    dcoffset_ramp_path #(
        .WIDTH(12), .DEPTH(2), .STEP(16), .RST_VAL(2048)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [11:0] din;
        logic [11:0] dout;
        logic        busy;
        logic        done;
        string       name;
    } vec_t;

    typedef struct {
        logic [11:0] dout;
        logic        busy;
        logic        done;
        string       name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: output seen with no expected record");
        end else begin
            e = sb.pop_front();
            if (bus.dout !== e.dout || bus.busy !== e.busy || bus.done !== e.done) begin
                errors++;
                $display("FAIL %s: got dout=%h busy=%b done=%b, need dout=%h busy=%b done=%b",
                         e.name, bus.dout, bus.busy, bus.done, e.dout, e.busy, e.done);
            end
        end
    endtask

    task automatic apply(input logic r, input logic e, input logic [11:0] d,
                         input logic [11:0] xd, input logic xb, input logic xdn,
                         input string nm);
        exp_t x;
        rst     = r;
        bus.en  = e;
        bus.din = d;
        x.dout = xd; x.busy = xb; x.done = xdn; x.name = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.din = 12'h000;

`ifdef DCOFFSET_SLEW_EN
        tbl.push_back('{1'b1, 1'b1, 12'hFFF, 12'h800, 1'b0, 1'b0, "reset_c0"});
        tbl.push_back('{1'b1, 1'b1, 12'hFFF, 12'h800, 1'b0, 1'b0, "reset_c1"});
        tbl.push_back('{1'b1, 1'b1, 12'hFFF, 12'h800, 1'b0, 1'b0, "reset_c2"});
        tbl.push_back('{1'b0, 1'b1, 12'h800, 12'h800, 1'b0, 1'b0, "release"});
        tbl.push_back('{1'b0, 1'b0, 12'h840, 12'h800, 1'b0, 1'b0, "up_fill0"});
        tbl.push_back('{1'b0, 1'b0, 12'h840, 12'h800, 1'b0, 1'b0, "up_fill1"});
        tbl.push_back('{1'b0, 1'b1, 12'h840, 12'h800, 1'b1, 1'b0, "up_load"});
        tbl.push_back('{1'b0, 1'b0, 12'h840, 12'h810, 1'b1, 1'b0, "up_s1"});
        tbl.push_back('{1'b0, 1'b0, 12'h840, 12'h820, 1'b1, 1'b0, "up_s2"});
        tbl.push_back('{1'b0, 1'b0, 12'h840, 12'h830, 1'b1, 1'b0, "up_s3"});
        tbl.push_back('{1'b0, 1'b0, 12'h840, 12'h840, 1'b0, 1'b1, "up_s4_done"});
        tbl.push_back('{1'b0, 1'b0, 12'h840, 12'h840, 1'b0, 1'b0, "up_settled"});
        tbl.push_back('{1'b1, 1'b0, 12'h7D9, 12'h800, 1'b0, 1'b0, "dn_reset"});
        tbl.push_back('{1'b0, 1'b0, 12'h7D9, 12'h800, 1'b0, 1'b0, "dn_fill0"});
        tbl.push_back('{1'b0, 1'b0, 12'h7D9, 12'h800, 1'b0, 1'b0, "dn_fill1"});
        tbl.push_back('{1'b0, 1'b1, 12'h7D9, 12'h800, 1'b1, 1'b0, "dn_load"});
        tbl.push_back('{1'b0, 1'b0, 12'h7D9, 12'h7F0, 1'b1, 1'b0, "dn_s1"});
        tbl.push_back('{1'b0, 1'b0, 12'h7D9, 12'h7E0, 1'b1, 1'b0, "dn_s2"});
        tbl.push_back('{1'b0, 1'b0, 12'h7D9, 12'h7D9, 1'b0, 1'b1, "dn_partial_done"});
        tbl.push_back('{1'b0, 1'b0, 12'h7D9, 12'h7D9, 1'b0, 1'b0, "dn_settled"});
`else
        tbl.push_back('{1'b1, 1'b1, 12'hFFF, 12'h800, 1'b0, 1'b0, "reset_c0"});
        tbl.push_back('{1'b1, 1'b1, 12'hFFF, 12'h800, 1'b0, 1'b0, "reset_c1"});
        tbl.push_back('{1'b1, 1'b1, 12'hFFF, 12'h800, 1'b0, 1'b0, "reset_c2"});
        tbl.push_back('{1'b0, 1'b0, 12'h800, 12'h800, 1'b0, 1'b0, "release"});
        tbl.push_back('{1'b0, 1'b0, 12'h800, 12'h800, 1'b0, 1'b0, "idle_hold"});
        tbl.push_back('{1'b0, 1'b1, 12'h123, 12'h800, 1'b0, 1'b1, "lat_e0"});
        tbl.push_back('{1'b0, 1'b1, 12'h123, 12'h800, 1'b0, 1'b1, "lat_e1"});
        tbl.push_back('{1'b0, 1'b1, 12'h123, 12'h123, 1'b0, 1'b1, "lat_e2"});
        tbl.push_back('{1'b0, 1'b0, 12'h456, 12'h123, 1'b0, 1'b0, "hold0"});
        tbl.push_back('{1'b0, 1'b0, 12'h789, 12'h123, 1'b0, 1'b0, "hold1"});
        tbl.push_back('{1'b0, 1'b1, 12'hABC, 12'h456, 1'b0, 1'b1, "load_tail"});
        tbl.push_back('{1'b0, 1'b0, 12'h000, 12'h456, 1'b0, 1'b0, "hold2"});
        tbl.push_back('{1'b0, 1'b1, 12'h000, 12'hABC, 1'b0, 1'b1, "load_abc"});
        tbl.push_back('{1'b0, 1'b1, 12'hFFF, 12'h000, 1'b0, 1'b1, "min_code"});
        tbl.push_back('{1'b0, 1'b1, 12'hFFF, 12'h000, 1'b0, 1'b1, "min_code2"});
        tbl.push_back('{1'b0, 1'b1, 12'hFFF, 12'hFFF, 1'b0, 1'b1, "max_code"});
        tbl.push_back('{1'b1, 1'b1, 12'h555, 12'h800, 1'b0, 1'b0, "reset_mid"});
        tbl.push_back('{1'b0, 1'b1, 12'h555, 12'h800, 1'b0, 1'b1, "post_reset"});
`endif

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].rst, tbl[i].en, tbl[i].din,
                  tbl[i].dout, tbl[i].busy, tbl[i].done, tbl[i].name);

`ifdef DCOFFSET_SLEW_EN
        // Retarget: the load edge still steps toward 0x900, then the ramp turns down.
        apply(1'b1, 1'b0, 12'h900, 12'h800, 1'b0, 1'b0, "rt_reset");
        apply(1'b0, 1'b0, 12'h900, 12'h800, 1'b0, 1'b0, "rt_fill0");
        apply(1'b0, 1'b0, 12'h900, 12'h800, 1'b0, 1'b0, "rt_fill1");
        apply(1'b0, 1'b1, 12'h7F8, 12'h800, 1'b1, 1'b0, "rt_load900");
        apply(1'b0, 1'b0, 12'h7F8, 12'h810, 1'b1, 1'b0, "rt_up1");
        apply(1'b0, 1'b0, 12'h7F8, 12'h820, 1'b1, 1'b0, "rt_up2");
        apply(1'b0, 1'b1, 12'h7F8, 12'h830, 1'b1, 1'b0, "rt_load7f8");
        apply(1'b0, 1'b0, 12'h7F8, 12'h820, 1'b1, 1'b0, "rt_dn1");
        apply(1'b0, 1'b0, 12'h7F8, 12'h810, 1'b1, 1'b0, "rt_dn2");
        apply(1'b0, 1'b0, 12'h7F8, 12'h800, 1'b1, 1'b0, "rt_dn3");
        apply(1'b0, 1'b0, 12'h7F8, 12'h7F8, 1'b0, 1'b1, "rt_done");
        apply(1'b0, 1'b0, 12'h7F8, 12'h7F8, 1'b0, 1'b0, "rt_single_done");

        // Reset mid-ramp at 0x860 aborts with no Done.
        apply(1'b1, 1'b0, 12'h900, 12'h800, 1'b0, 1'b0, "mr_reset");
        apply(1'b0, 1'b0, 12'h900, 12'h800, 1'b0, 1'b0, "mr_fill0");
        apply(1'b0, 1'b0, 12'h900, 12'h800, 1'b0, 1'b0, "mr_fill1");
        apply(1'b0, 1'b1, 12'h900, 12'h800, 1'b1, 1'b0, "mr_load");
        apply(1'b0, 1'b0, 12'h900, 12'h810, 1'b1, 1'b0, "mr_s1");
        apply(1'b0, 1'b0, 12'h900, 12'h820, 1'b1, 1'b0, "mr_s2");
        apply(1'b0, 1'b0, 12'h900, 12'h830, 1'b1, 1'b0, "mr_s3");
        apply(1'b0, 1'b0, 12'h900, 12'h840, 1'b1, 1'b0, "mr_s4");
        apply(1'b0, 1'b0, 12'h900, 12'h850, 1'b1, 1'b0, "mr_s5");
        apply(1'b0, 1'b0, 12'h900, 12'h860, 1'b1, 1'b0, "mr_s6");
        apply(1'b1, 1'b0, 12'h900, 12'h800, 1'b0, 1'b0, "mr_abort");
        apply(1'b0, 1'b0, 12'h900, 12'h800, 1'b0, 1'b0, "mr_no_done");

        // Loading a target equal to Dout gives neither Busy nor Done.
        apply(1'b0, 1'b1, 12'h800, 12'h800, 1'b0, 1'b0, "zero_delta_load");
        apply(1'b0, 1'b0, 12'h800, 12'h800, 1'b0, 1'b0, "zero_delta_after");
`else
        // A single-cycle EN loads once and pulses Done once.
        apply(1'b0, 1'b0, 12'h555, 12'h800, 1'b0, 1'b0, "pulse_pre");
        apply(1'b0, 1'b1, 12'h000, 12'h555, 1'b0, 1'b1, "pulse_load");
        apply(1'b0, 1'b0, 12'h000, 12'h555, 1'b0, 1'b0, "pulse_hold0");
        apply(1'b0, 1'b0, 12'h000, 12'h555, 1'b0, 1'b0, "pulse_hold1");
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d records left, need 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
